// File: rtl/hdmi_stream_timing.sv
// Video timing generator plus one-pixel-per-beat AXI-Stream unpacker for the pixel clock.
// Frame alignment is enforced with tlast; misaligned frames are dropped until the next frame boundary.
module hdmi_stream_timing #(
  parameter int                   COLOR_W   = 8,
  parameter int                   H_ACTIVE  = 640,
  parameter int                   H_FP      = 16,
  parameter int                   H_SYNC    = 96,
  parameter int                   H_BP      = 48,
  parameter int                   V_ACTIVE  = 480,
  parameter int                   V_FP      = 10,
  parameter int                   V_SYNC    = 2,
  parameter int                   V_BP      = 33,
  parameter bit                   HSYNC_POL = 1'b0,
  parameter bit                   VSYNC_POL = 1'b0,
  parameter logic [3*COLOR_W-1:0] UF_COLOR  = 24'hFF00FF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*COLOR_W-1:0] s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  output logic                 s_tready,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 blank,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start,
  output logic                 underflow,
  output logic                 frame_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  typedef enum logic [1:0] {RUN, RESYNC, WAIT_SOF} state_t;

  logic [HW-1:0]        h_q, h_d;
  logic [VW-1:0]        v_q, v_d;
  state_t               state_q, state_d;
  logic [3*COLOR_W-1:0] pix_q, pix_d;
  logic                 blank_q, hs_q, vs_q, fs_q, uf_q, ferr_q;
  logic                 hs_d, vs_d, uf_d, ferr_d;
  logic                 h_last, v_last, active, last_px, tready_c, accept;

  always_comb begin
    h_last  = (int'(h_q) == H_TOTAL - 1);
    v_last  = (int'(v_q) == V_TOTAL - 1);
    h_d     = h_last ? '0 : h_q + HW'(1);
    v_d     = h_last ? (v_last ? '0 : v_q + VW'(1)) : v_q;
    active  = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    last_px = (int'(h_q) == H_ACTIVE - 1) && (int'(v_q) == V_ACTIVE - 1);
    hs_d    = ((int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC))
              ? HSYNC_POL : ~HSYNC_POL;
    vs_d    = ((int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC))
              ? VSYNC_POL : ~VSYNC_POL;

    case (state_q)
      RUN:     tready_c = active;
      RESYNC:  tready_c = 1'b1;
      default: tready_c = 1'b0;
    endcase
    accept = s_tvalid & tready_c;

    state_d = state_q;
    pix_d   = '0;
    uf_d    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (active) begin
          if (s_tvalid) pix_d = s_tdata;
          else begin
            pix_d = UF_COLOR;
            uf_d  = 1'b1;
          end
        end
        // A starved last pixel is treated the same as a missing tlast.
        if (accept && s_tlast && !last_px) begin
          ferr_d  = 1'b1;
          state_d = WAIT_SOF;
        end else if (last_px && !(accept && s_tlast)) begin
          ferr_d  = 1'b1;
          state_d = RESYNC;
        end
      end
      RESYNC:   if (accept && s_tlast) state_d = WAIT_SOF;
      WAIT_SOF: if (h_last && v_last) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  assign s_tready = rst & tready_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q     <= '0;
      v_q     <= '0;
      state_q <= RUN;
      pix_q   <= '0;
      blank_q <= 1'b1;
      hs_q    <= ~HSYNC_POL;
      vs_q    <= ~VSYNC_POL;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      state_q <= state_d;
      pix_q   <= pix_d;
      blank_q <= ~active;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= (h_q == '0) && (v_q == '0);
      uf_q    <= uf_d;
      ferr_q  <= ferr_d;
    end
  end

  assign red         = pix_q[3*COLOR_W-1 -: COLOR_W];
  assign green       = pix_q[2*COLOR_W-1 -: COLOR_W];
  assign blue        = pix_q[COLOR_W-1:0];
  assign blank       = blank_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_hdmi_stream_timing.sv
// Directed bench: a small 4x3 raster (7x6 total, positive syncs) for stream behaviour,
// plus a default 640x480 instance checked over its first line.
module tb_hdmi_stream_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_d;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [7:0]  red, green, blue;
  logic        blank, hsync, vsync, frame_start, underflow, frame_err;

  logic [23:0] d_tdata;
  logic        d_tvalid, d_tlast, d_tready;
  logic [7:0]  d_red, d_green, d_blue;
  logic        d_blank, d_hsync, d_vsync, d_frame_start, d_underflow, d_frame_err;

  hdmi_stream_timing #(
    .COLOR_W(8), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .UF_COLOR(24'hFF00FF)
  ) u_dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .red(red), .green(green), .blue(blue), .blank(blank),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .underflow(underflow),
    .frame_err(frame_err)
  );

  hdmi_stream_timing u_def (
    .clk(clk), .rst(rst_d), .s_tdata(d_tdata), .s_tvalid(d_tvalid), .s_tlast(d_tlast),
    .s_tready(d_tready), .red(d_red), .green(d_green), .blue(d_blue), .blank(d_blank),
    .hsync(d_hsync), .vsync(d_vsync), .frame_start(d_frame_start), .underflow(d_underflow),
    .frame_err(d_frame_err)
  );

  int   errors = 0, checks = 0;
  int   h = 0, v = 0, ph = 0, pv = 0;
  int   sn = 0, b = 0, src_len = 12;
  logic acc, rdy;

  function automatic logic [23:0] pix(input int s);
    logic [7:0] x;
    x = s[7:0];
    return {x, x ^ 8'h3C, x + 8'd7};
  endfunction

  // One pixel clock: present the current stream beat, advance the source on handshake,
  // and leave (ph,pv) naming the raster position whose registered outputs are now visible.
  task automatic step(input bit tv);
    @(negedge clk);
    s_tvalid = tv;
    s_tdata  = pix(sn);
    s_tlast  = (b == src_len - 1);
    #1;
    rdy = s_tready;
    acc = s_tvalid & s_tready;
    @(posedge clk);
    if (acc) begin
      sn++;
      if (s_tlast) b = 0; else b++;
    end
    ph = h; pv = v;
    h++;
    if (h == 7) begin h = 0; v++; if (v == 6) v = 0; end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; rst_d = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    d_tvalid = 1'b1; d_tlast = 1'b0; d_tdata = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({red, green, blue} !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 000000", {red, green, blue}); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b want 1", blank); end
    checks++; if (hsync !== 1'b0 || vsync !== 1'b0) begin errors++; $display("FAIL reset_sync got %b%b want 00", hsync, vsync); end
    checks++; if ({frame_start, underflow, frame_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {frame_start, underflow, frame_err}); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_tready); end
    checks++; if (d_hsync !== 1'b1 || d_vsync !== 1'b1) begin errors++; $display("FAIL reset_def_sync got %b%b want 11", d_hsync, d_vsync); end
    rst = 1'b1;
    h = 0; v = 0; b = 0; src_len = 12;
  endtask

  task automatic test_raster(input int nf);
    int base; bit act; int p; logic [23:0] ex;
    base = sn;
    for (int c = 0; c < 42 * nf; c++) begin
      if (h == 0 && v == 0) base = sn;
      step(1'b1);
      act = (ph < 4) && (pv < 3);
      p   = pv * 4 + ph;
      ex  = act ? pix(base + p) : 24'h0;
      checks++; if (rdy !== act) begin errors++; $display("FAIL raster_tready h=%0d v=%0d got %b want %b", ph, pv, rdy, act); end
      checks++; if (blank !== !act) begin errors++; $display("FAIL raster_blank h=%0d v=%0d got %b want %b", ph, pv, blank, !act); end
      checks++; if ({red, green, blue} !== ex) begin errors++; $display("FAIL raster_rgb h=%0d v=%0d got %h want %h", ph, pv, {red, green, blue}, ex); end
      checks++; if (hsync !== (ph == 5)) begin errors++; $display("FAIL raster_hsync h=%0d v=%0d got %b", ph, pv, hsync); end
      checks++; if (vsync !== (pv == 4)) begin errors++; $display("FAIL raster_vsync h=%0d v=%0d got %b", ph, pv, vsync); end
      checks++; if (frame_start !== (ph == 0 && pv == 0)) begin errors++; $display("FAIL raster_fs h=%0d v=%0d got %b", ph, pv, frame_start); end
      checks++; if (underflow !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL raster_err h=%0d v=%0d got uf=%b fe=%b want 0 0", ph, pv, underflow, frame_err); end
    end
  endtask

  // Three starved slots shift the stream, so tlast arrives late and RESYNC mops up beats 9..11.
  task automatic test_underflow;
    int base; bit act, gap, rexp; int p; logic [23:0] ex;
    base = sn;
    for (int c = 0; c < 42; c++) begin
      act = (h < 4) && (v < 3);
      p   = v * 4 + h;
      gap = act && (p >= 2) && (p <= 4);
      step(!gap);
      if (!act) ex = 24'h0;
      else if (gap) ex = 24'hFF00FF;
      else if (p < 2) ex = pix(base + p);
      else ex = pix(base + p - 3);
      rexp = act || (pv == 2 && ph >= 4);
      checks++; if (rdy !== rexp) begin errors++; $display("FAIL uf_tready h=%0d v=%0d got %b want %b", ph, pv, rdy, rexp); end
      checks++; if ({red, green, blue} !== ex) begin errors++; $display("FAIL uf_rgb h=%0d v=%0d got %h want %h", ph, pv, {red, green, blue}, ex); end
      checks++; if (underflow !== gap) begin errors++; $display("FAIL uf_pulse h=%0d v=%0d got %b want %b", ph, pv, underflow, gap); end
      checks++; if (frame_err !== (ph == 3 && pv == 2)) begin errors++; $display("FAIL uf_frame_err h=%0d v=%0d got %b", ph, pv, frame_err); end
    end
    checks++; if (sn !== base + 12) begin errors++; $display("FAIL uf_beats_consumed got %0d want %0d", sn - base, 12); end
  endtask

  task automatic test_early_tlast;
    int base; bit act; int p; logic [23:0] ex;
    base = sn; src_len = 6;
    for (int c = 0; c < 42; c++) begin
      step(1'b1);
      act = (ph < 4) && (pv < 3);
      p   = pv * 4 + ph;
      ex  = (act && p <= 5) ? pix(base + p) : 24'h0;
      checks++; if (rdy !== (act && p <= 5)) begin errors++; $display("FAIL early_tready h=%0d v=%0d got %b", ph, pv, rdy); end
      checks++; if ({red, green, blue} !== ex) begin errors++; $display("FAIL early_rgb h=%0d v=%0d got %h want %h", ph, pv, {red, green, blue}, ex); end
      checks++; if (blank !== !act) begin errors++; $display("FAIL early_blank h=%0d v=%0d got %b", ph, pv, blank); end
      checks++; if (frame_err !== (ph == 1 && pv == 1)) begin errors++; $display("FAIL early_frame_err h=%0d v=%0d got %b", ph, pv, frame_err); end
    end
    checks++; if (sn !== base + 6) begin errors++; $display("FAIL early_beats_consumed got %0d want 6", sn - base); end
    src_len = 12;
  endtask

  task automatic test_reset_resync;
    src_len = 100;
    for (int c = 0; c < 19; c++) begin
      step(1'b1);
      if (ph == 3 && pv == 2) begin
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL rs_frame_err got %b want 1", frame_err); end
      end
    end
    checks++; if (!(ph == 4 && pv == 2) || rdy !== 1'b1) begin errors++; $display("FAIL rs_resync_tready h=%0d v=%0d got %b want 1", ph, pv, rdy); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({red, green, blue} !== 24'h0 || blank !== 1'b1) begin errors++; $display("FAIL rs_async_video got %h blank=%b want 000000 1", {red, green, blue}, blank); end
    checks++; if (hsync !== 1'b0 || vsync !== 1'b0) begin errors++; $display("FAIL rs_async_sync got %b%b want 00", hsync, vsync); end
    checks++; if ({frame_start, underflow, frame_err, s_tready} !== 4'b0000) begin errors++; $display("FAIL rs_async_misc got %b want 0000", {frame_start, underflow, frame_err, s_tready}); end
    @(posedge clk); #1;
    checks++; if (blank !== 1'b1 || s_tready !== 1'b0) begin errors++; $display("FAIL rs_held got blank=%b rdy=%b want 1 0", blank, s_tready); end
    rst = 1'b1;
    h = 0; v = 0; b = 0; src_len = 12;
    test_raster(1);
  endtask

  task automatic test_default_line;
    logic r; int blank_lo = 0, hs_lo = 0, hs_first = -1;
    @(posedge clk); #1 rst_d = 1'b1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      r = d_tready;
      @(posedge clk); #1;
      if (!d_blank) blank_lo++;
      if (!d_hsync) begin hs_lo++; if (hs_first < 0) hs_first = i; end
      checks++; if (d_hsync !== !(i >= 656 && i < 752)) begin errors++; $display("FAIL def_hsync i=%0d got %b", i, d_hsync); end
      checks++; if (d_blank !== (i >= 640) || r !== (i < 640)) begin errors++; $display("FAIL def_blank i=%0d got blank=%b rdy=%b", i, d_blank, r); end
      checks++; if (d_red !== ((i < 640) ? 8'h12 : 8'h00)) begin errors++; $display("FAIL def_red i=%0d got %h", i, d_red); end
      checks++; if (d_vsync !== 1'b1 || d_underflow !== 1'b0 || d_frame_err !== 1'b0 || d_frame_start !== (i == 0)) begin errors++; $display("FAIL def_status i=%0d got vs=%b uf=%b fe=%b fs=%b", i, d_vsync, d_underflow, d_frame_err, d_frame_start); end
    end
    checks++; if (blank_lo !== 640) begin errors++; $display("FAIL def_active_count got %0d want 640", blank_lo); end
    checks++; if (hs_lo !== 96 || hs_first !== 656) begin errors++; $display("FAIL def_hsync_window got %0d@%0d want 96@656", hs_lo, hs_first); end
  endtask

  initial begin
    test_reset;
    test_raster(2);
    test_underflow;
    test_raster(1);
    test_early_tlast;
    test_raster(1);
    test_reset_resync;
    test_default_line;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
